alu_muldiv_unit: RTL
====================

# alu_muldiv_unit

Iterative multiply/divide unit that consumes the same two ALU operands as the main ALU: operand 1 from the register file, operand 2 from the ALU input-2 selector. It implements the eight RISC-V M-extension operations with a start/busy/done handshake. The control unit stalls the pipeline while `busy` is high. Multiply uses shift-add and divide uses restoring division, one bit per cycle, for 32 iteration cycles.

## Interface
Parameters: none. Width is fixed at 32.
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only when not busy
- `funct3`  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `aluIn1`  in  32  operand 1 (multiplicand / dividend)
- `aluIn2`  in  32  operand 2 (multiplier / divisor), driven by the input-2 selector
- `busy`  out  1  high while iterating
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle
- `result`  out  32  final value; held until the next accepted start

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE or DONE, start=1:** latch `funct3` and both operands; compute their magnitudes and the result sign; clear the 6-bit iteration counter; go to CALC.
  - Signedness: operand 1 is signed for MULH, MULHSU, DIV and REM. Operand 2 is signed for MULH, DIV and REM.
  - Result sign:
    - multiply: XOR of the operand signs
    - quotient: XOR of the operand signs
    - remainder: sign of the dividend
- **Shortcut cases** go straight to DONE and never enter CALC:
  - Divide by zero (aluIn2=0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give aluIn1.
  - Signed overflow (DIV/REM with aluIn1=0x80000000 and aluIn2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- **CALC:** one iteration per cycle. The counter increments and leaves after iteration 31 (32 cycles).
  - Multiply: 64-bit product register, shift-add on the multiplier LSB.
  - Divide: 64-bit remainder/quotient register. Shift left, trial-subtract the divisor magnitude, set the quotient bit if the result is non-negative.
- **CALC exit:** negate the 64-bit product or the quotient/remainder when the sign requires it. Select the output:
  - MUL: low 32 bits
  - MULH, MULHSU, MULHU: high 32 bits
  - DIV/DIVU: quotient
  - REM/REMU: remainder
  
  Register the selected value into `result` and go to DONE.
- **DONE:** lasts one cycle, then returns to IDLE. A start in DONE is accepted exactly as in IDLE (back-to-back operation).
- **start while busy (CALC):** ignored; latched operands and `funct3` are unaffected.
- **Operand/funct3 changes after acceptance:** no effect on the result.
- **Reset (any state, including mid-CALC):** state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0. The in-flight operation is discarded.

## Timing
- **Normal operation:** start high in cycle 0 → busy high in cycles 1–32 → done high and result valid in cycle 33 (busy low).
- **Shortcut cases:** start in cycle 0 → done in cycle 1; busy never asserts.
- `busy` and `done` are never high in the same cycle.
- `busy` and `done` are registered outputs, decoded from the state register.
- `result` changes only on the edge that enters DONE, or on reset.
- Throughput: one operation per 33 cycles with back-to-back starts.

## Test plan
- **Reset during CALC:** start MUL 3×5, assert rst in cycle 10 → busy=0, done=0, result=0 immediately. A new start gives the correct result with no stale state.
- **Multiply:**
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001
  - MULH → 0x00000000
  - MULHU → 0xFFFFFFFE
  - MULHSU (‑1 × 0xFFFFFFFF) → 0xFFFFFFFF
  
  Each has done exactly in cycle 33.
- **Signed divide:** DIV ‑7/2 → 0xFFFFFFFD; REM ‑7/2 → 0xFFFFFFFF; DIVU 7/2 → 3; REMU 7/2 → 1.
- **Shortcuts:**
  - DIV 5/0 → 0xFFFFFFFF, done in cycle 1, busy never high
  - REMU 5/0 → 5
  - DIV 0x80000000/‑1 → 0x80000000
  - REM 0x80000000/‑1 → 0
- **Handshake:**
  - Pulse start again in cycles 5 and 20 with different operands → ignored; the first result is unchanged.
  - Start asserted during the done cycle → accepted; the second done arrives 33 cycles later.
- **Random regression:** 10k random operand/funct3 pairs, including 0, 1, ‑1 and 0x80000000, checked against a 64-bit reference model. Check that `result` holds between operations.

Source files
------------

// File: rtl/alu_muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, with a start/busy/done handshake.
module alu_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] aluIn1,
    input  logic [31:0] aluIn2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    // One-hot-ish encoding so busy/done are state flops, never high together.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic [1:0]  state;
    logic [2:0]  op;
    logic [63:0] acc;
    logic [31:0] opb;
    logic        neg;
    logic [5:0]  cnt;

    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] mag1, mag2;
    logic        div_zero, overflow, shortcut;
    logic [31:0] shortcut_val;
    logic        res_neg;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        a_signed     = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
        b_signed     = funct3 inside {3'b001, 3'b100, 3'b110};
        a_neg        = a_signed & aluIn1[31];
        b_neg        = b_signed & aluIn2[31];
        mag1         = a_neg ? -aluIn1 : aluIn1;
        mag2         = b_neg ? -aluIn2 : aluIn2;
        div_zero     = funct3[2] && (aluIn2 == 32'h0);
        overflow     = funct3[2] && !funct3[0] &&
                       (aluIn1 == 32'h8000_0000) && (aluIn2 == 32'hFFFF_FFFF);
        shortcut     = div_zero || overflow;
        shortcut_val = 32'h0;
        if (div_zero)
            shortcut_val = funct3[1] ? aluIn1 : 32'hFFFF_FFFF;
        else if (overflow)
            shortcut_val = funct3[1] ? 32'h0 : 32'h8000_0000;
        // Remainder takes the dividend sign; product and quotient take the XOR.
        res_neg      = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    end

    logic [32:0] mul_sum;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] acc_next;
    logic [63:0] mul_fin;
    logic [31:0] div_sel, div_fin, fin_val;

    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'h0);
        // The shifted partial remainder needs 33 bits when the divisor is >= 2^31.
        div_ge   = acc[63:31] >= {1'b0, opb};
        div_diff = acc[62:31] - opb;
        acc_next = acc;
        if (op[2])
            acc_next = div_ge ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
        else
            acc_next = {mul_sum, acc[31:1]};

        mul_fin = neg ? -acc_next : acc_next;
        div_sel = op[1] ? acc_next[63:32] : acc_next[31:0];
        div_fin = neg ? -div_sel : div_sel;
        fin_val = div_fin;
        if (!op[2])
            fin_val = (op[1:0] == 2'b00) ? mul_fin[31:0] : mul_fin[63:32];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op     <= 3'b000;
            acc    <= 64'h0;
            opb    <= 32'h0;
            neg    <= 1'b0;
            cnt    <= 6'd0;
            result <= 32'h0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        op  <= funct3;
                        neg <= res_neg;
                        cnt <= 6'd0;
                        if (shortcut) begin
                            result <= shortcut_val;
                            state  <= DONE;
                        end else begin
                            // Multiply: acc low half holds the multiplier, opb the multiplicand.
                            // Divide: acc low half holds the dividend, opb the divisor.
                            acc   <= {32'h0, funct3[2] ? mag1 : mag2};
                            opb   <= funct3[2] ? mag2 : mag1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        result <= fin_val;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = state[0];
    assign done = state[1];

endmodule
